spi_slave_regfile: RTL and testbench

SPI_SLAVE_REGFILE -- requirements
Module: spi_slave_regfile

---
 rtl/spi_slave_regfile.sv | 233 +++++++++++++++++++++++
 tb/tb_spi_slave_regfile.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_slave_regfile : SPI mode-1 slave giving read/write access to a small  |
// | bank of channel registers. Optional parity: define SPI_SLV_PARITY_EN.     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module spi_slave_regfile #(
  parameter int                DATA_W  = 8,
  parameter int                NUM_CH  = 4,
  parameter int                ADDR_W  = 2,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sck,
  input  logic                       cs_n,
  input  logic                       mosi,
  output logic                       miso,
  output logic                       miso_oe,
  input  logic                       err_clr,
  output logic [NUM_CH*DATA_W-1:0]   ch_data,
  output logic                       wr_pulse,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       busy,
  output logic                       frame_err
);

`ifdef SPI_SLV_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int DLEN  = DATA_W + PAR_W;
  localparam int TX_W  = DATA_W + PAR_W;
  localparam int RX_W  = DATA_W - 1 + PAR_W;
  localparam int CNT_W = $clog2(ADDR_W + DLEN + 2);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DLEN - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMD  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        sck_sync_q, cs_sync_q, mosi_sync_q, flush_q;
  logic              sck_prev_q, cs_prev_q;
  logic              sck_s, cs_s, mosi_s, sck_rise, sck_fall, cs_fall;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W:0]   cmd_q, cmd_d;
  logic [RX_W-1:0]   rx_q, rx_d;
  logic [TX_W-1:0]   tx_q, tx_d;
  logic              miso_q, miso_d;
  logic [DATA_W-1:0] regs_q [NUM_CH];
  logic [DATA_W-1:0] regs_d [NUM_CH];
  logic              wr_pulse_q, wr_pulse_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              frame_err_q, frame_err_d;
  logic              armed_q, armed_d;

  logic [ADDR_W:0]   w_cmd_next;
  logic [DATA_W-1:0] w_snap;
  logic [TX_W-1:0]   w_tx_load;
  logic [DATA_W-1:0] w_final;
  logic              w_par_ok;
  logic              w_wr_hit;

  // Synchronisers idle at the bus-quiet levels so reset never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= 2'b00;
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b00;
      flush_q     <= 2'b00;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[0], sck};
      cs_sync_q   <= {cs_sync_q[0], cs_n};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
      flush_q     <= {flush_q[0], 1'b1};
      sck_prev_q  <= sck_sync_q[1];
      cs_prev_q   <= cs_sync_q[1];
    end
  end

  assign sck_s    = sck_sync_q[1];
  assign cs_s     = cs_sync_q[1];
  assign mosi_s   = mosi_sync_q[1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;

  assign w_cmd_next = {cmd_q[ADDR_W-1:0], mosi_s};

`ifdef SPI_SLV_PARITY_EN
  assign w_tx_load = {w_snap, ~^w_snap};
  assign w_final   = rx_q;
  assign w_par_ok  = ^{cmd_q, rx_q, mosi_s};
`else
  assign w_tx_load = w_snap;
  assign w_final   = {rx_q, mosi_s};
  assign w_par_ok  = 1'b1;
`endif

  // Unmapped addresses read as zero and never match a write.
  always_comb begin
    w_snap   = '0;
    w_wr_hit = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_cmd_next[ADDR_W-1:0] == ADDR_W'(i)) w_snap = regs_q[i];
      if (cmd_q[ADDR_W-1:0] == ADDR_W'(i))      w_wr_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cs_s) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (cs_fall && armed_q) state_d = S_CMD;
        S_CMD:   if (sck_fall && cnt_q == CMD_LAST) state_d = S_DATA;
        S_DATA:  if (sck_fall && cnt_q == DATA_LAST) state_d = S_DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    miso_d      = miso_q;
    regs_d      = regs_q;
    wr_pulse_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    // A frame may only start once cs_n has been seen high after reset.
    armed_d     = armed_q | (flush_q[1] & cs_s);
    frame_err_d = frame_err_q & ~err_clr;

    if (cs_s || state_q == S_IDLE) begin
      cnt_d  = '0;
      miso_d = 1'b0;
      if (cs_s && (state_q == S_CMD || state_q == S_DATA)) frame_err_d = 1'b1;
    end else begin
      case (state_q)
        S_CMD: begin
          if (sck_fall) begin
            cmd_d = w_cmd_next;
            if (cnt_q == CMD_LAST) begin
              cnt_d = '0;
              tx_d  = w_tx_load;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (sck_rise) begin
            miso_d = tx_q[TX_W-1];
            tx_d   = TX_W'({tx_q, 1'b0});
          end
          if (sck_fall) begin
            rx_d  = RX_W'({rx_q, mosi_s});
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == DATA_LAST) begin
              cnt_d  = '0;
              miso_d = 1'b0;
              if (!w_par_ok) frame_err_d = 1'b1;
              if (cmd_q[ADDR_W] && w_wr_hit && w_par_ok) begin
                for (int i = 0; i < NUM_CH; i++) begin
                  if (cmd_q[ADDR_W-1:0] == ADDR_W'(i)) regs_d[i] = w_final;
                end
                wr_pulse_d = 1'b1;
                wr_addr_d  = cmd_q[ADDR_W-1:0];
              end
            end
          end
        end
        default: miso_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      cmd_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      miso_q      <= 1'b0;
      regs_q      <= '{default: RST_VAL};
      wr_pulse_q  <= 1'b0;
      wr_addr_q   <= '0;
      frame_err_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      regs_q      <= regs_d;
      wr_pulse_q  <= wr_pulse_d;
      wr_addr_q   <= wr_addr_d;
      frame_err_q <= frame_err_d;
      armed_q     <= armed_d;
    end
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    miso      = miso_q;
    miso_oe   = ~cs_s;
    wr_pulse  = wr_pulse_q;
    wr_addr   = wr_addr_q;
    frame_err = frame_err_q;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign ch_data[g*DATA_W +: DATA_W] = regs_q[g];
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_spi_slave_regfile : two slaves (4 and 3 channels) on one SPI bus,      |
// | scoreboarded against an array model. Honours SPI_SLV_PARITY_EN.           |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_spi_slave_regfile;

`ifdef SPI_SLV_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int DW = 8;
  localparam int AW = 2;
  localparam int FL = 1 + AW + DW + PW;
  localparam int RW = DW + PW;

  logic clk = 1'b0, rst_n = 1'b0, sck = 1'b0, cs_n = 1'b1, mosi = 1'b0, err_clr = 1'b0;
  logic miso_a, oe_a, wp_a, busy_a, fe_a;
  logic miso_b, oe_b, wp_b, busy_b, fe_b;
  logic [1:0]  wa_a, wa_b;
  logic [31:0] cd_a;
  logic [23:0] cd_b;

  always #5 clk = ~clk;

  spi_slave_regfile #(.DATA_W(8), .NUM_CH(4), .ADDR_W(2), .RST_VAL(8'h00)) dut_a (
    .clk(clk), .rst_n(rst_n), .sck(sck), .cs_n(cs_n), .mosi(mosi),
    .miso(miso_a), .miso_oe(oe_a), .err_clr(err_clr), .ch_data(cd_a),
    .wr_pulse(wp_a), .wr_addr(wa_a), .busy(busy_a), .frame_err(fe_a));

  spi_slave_regfile #(.DATA_W(8), .NUM_CH(3), .ADDR_W(2), .RST_VAL(8'h5C)) dut_b (
    .clk(clk), .rst_n(rst_n), .sck(sck), .cs_n(cs_n), .mosi(mosi),
    .miso(miso_b), .miso_oe(oe_b), .err_clr(err_clr), .ch_data(cd_b),
    .wr_pulse(wp_b), .wr_addr(wa_b), .busy(busy_b), .frame_err(fe_b));

  int errors = 0;
  int checks = 0;

  logic [7:0] m_a [4];
  logic [7:0] m_b [3];
  bit me_a, me_b;

  logic [9:0]    wq_a[$], wq_b[$];
  logic [RW-1:0] rx_exp_a[$], rx_exp_b[$], rx_act_a[$], rx_act_b[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Write scoreboard: every observed pulse must match the next expected commit.
  always @(negedge clk) begin
    logic [9:0] e;
    if (rst_n && wp_a) begin
      if (wq_a.size() == 0) chk("a_wr_spurious", {31'b0, wp_a}, 32'd0);
      else begin
        e = wq_a.pop_front();
        chk("a_wr_addr", {30'b0, wa_a}, {30'b0, e[9:8]});
        chk("a_wr_data", {24'b0, cd_a[e[9:8]*8 +: 8]}, {24'b0, e[7:0]});
      end
    end
    if (rst_n && wp_b) begin
      if (wq_b.size() == 0) chk("b_wr_spurious", {31'b0, wp_b}, 32'd0);
      else begin
        e = wq_b.pop_front();
        chk("b_wr_addr", {30'b0, wa_b}, {30'b0, e[9:8]});
        chk("b_wr_data", {24'b0, cd_b[e[9:8]*8 +: 8]}, {24'b0, e[7:0]});
      end
    end
  end

  // Read scoreboard: captured miso words against expectations pushed at issue.
  always @(negedge clk) begin
    if (rx_act_a.size() > 0) begin
      if (rx_exp_a.size() == 0) chk("a_rd_unexpected", 32'(rx_act_a.pop_front()), 32'hFFFF_FFFF);
      else chk("a_rd_miso", 32'(rx_act_a.pop_front()), 32'(rx_exp_a.pop_front()));
    end
    if (rx_act_b.size() > 0) begin
      if (rx_exp_b.size() == 0) chk("b_rd_unexpected", 32'(rx_act_b.pop_front()), 32'hFFFF_FFFF);
      else chk("b_rd_miso", 32'(rx_act_b.pop_front()), 32'(rx_exp_b.pop_front()));
    end
  end

  function automatic logic [RW-1:0] rd_word(input logic [7:0] v);
`ifdef SPI_SLV_PARITY_EN
    return {v, ~^v};
`else
    return v;
`endif
  endfunction

  task automatic pulse(input logic b, output logic ma, output logic mb);
    @(negedge clk); mosi = b; sck = 1'b1;
    repeat (6) @(negedge clk);
    ma = miso_a; mb = miso_b;
    sck = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) chk($sformatf("%s_a_ch%0d", tag, i), {24'b0, cd_a[i*8 +: 8]}, {24'b0, m_a[i]});
    for (int i = 0; i < 3; i++) chk($sformatf("%s_b_ch%0d", tag, i), {24'b0, cd_b[i*8 +: 8]}, {24'b0, m_b[i]});
  endtask

  task automatic clear_err();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    me_a = 1'b0; me_b = 1'b0;
    repeat (2) @(negedge clk);
    chk("a_err_clr", {31'b0, fe_a}, 32'd0);
    chk("b_err_clr", {31'b0, fe_b}, 32'd0);
  endtask

  task automatic frame(input bit rw, input logic [1:0] addr, input logic [7:0] data,
                       input bit bad_par, input int nbits, input int extra);
    logic [FL-1:0] bits;
    logic [RW-1:0] cap_a, cap_b;
    logic ma, mb;
    bit full, par_ok;
`ifdef SPI_SLV_PARITY_EN
    bits   = {rw, addr, data, (~^{rw, addr, data}) ^ bad_par};
    par_ok = !bad_par;
`else
    bits   = {rw, addr, data};
    par_ok = 1'b1;
`endif
    full  = (nbits >= FL);
    cap_a = '0; cap_b = '0;
    if (full) begin
      rx_exp_a.push_back(rd_word(addr < 4 ? m_a[addr] : 8'h00));
      rx_exp_b.push_back(rd_word(addr < 3 ? m_b[addr] : 8'h00));
      if (rw && par_ok) begin
        if (addr < 4) begin m_a[addr] = data; wq_a.push_back({addr, data}); end
        if (addr < 3) begin m_b[addr] = data; wq_b.push_back({addr, data}); end
      end
      if (!par_ok) begin me_a = 1'b1; me_b = 1'b1; end
    end else begin
      me_a = 1'b1; me_b = 1'b1;
    end

    @(negedge clk); cs_n = 1'b0;
    repeat (20) @(negedge clk);
    chk("a_busy_in_frame", {31'b0, busy_a}, 32'd1);
    chk("b_oe_in_frame", {31'b0, oe_b}, 32'd1);
    for (int i = 0; i < nbits && i < FL; i++) begin
      pulse(bits[FL-1-i], ma, mb);
      if (i >= 1 + AW) begin
        cap_a = {cap_a[RW-2:0], ma};
        cap_b = {cap_b[RW-2:0], mb};
      end else begin
        chk("a_miso_cmd", {31'b0, ma}, 32'd0);
      end
    end
    if (full) begin
      for (int i = 0; i < extra; i++) begin
        pulse(1'b1, ma, mb);
        chk("a_miso_done", {31'b0, ma}, 32'd0);
        chk("b_miso_done", {31'b0, mb}, 32'd0);
      end
    end
    repeat (10) @(negedge clk);
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
    if (full) begin rx_act_a.push_back(cap_a); rx_act_b.push_back(cap_b); end
    chk("a_busy_idle", {31'b0, busy_a}, 32'd0);
    chk("a_oe_idle", {31'b0, oe_a}, 32'd0);
    chk("a_miso_idle", {31'b0, miso_a}, 32'd0);
    chk("a_frame_err", {31'b0, fe_a}, {31'b0, me_a});
    chk("b_frame_err", {31'b0, fe_b}, {31'b0, me_b});
    check_regs("post");
  endtask

  task automatic reset_mid_write();
    logic [10:0] bits;
    logic ma, mb;
    bits = {1'b1, 2'b00, 8'hF0};
    @(negedge clk); cs_n = 1'b0;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 6; i++) pulse(bits[10-i], ma, mb);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) m_a[i] = 8'h00;
    for (int i = 0; i < 3; i++) m_b[i] = 8'h5C;
    check_regs("in_rst");
    chk("a_busy_rst", {31'b0, busy_a}, 32'd0);
    rst_n = 1'b1;
    for (int i = 6; i < 11; i++) pulse(bits[10-i], ma, mb);
    repeat (10) @(negedge clk);
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
    check_regs("after_rst");
    clear_err();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rw, bad;
    logic [1:0] ad;
    logic [7:0] dt;
    int nb;

    for (int i = 0; i < 4; i++) m_a[i] = 8'h00;
    for (int i = 0; i < 3; i++) m_b[i] = 8'h5C;
    me_a = 1'b0; me_b = 1'b0;

    repeat (5) @(negedge clk);
    chk("rst_miso", {31'b0, miso_a}, 32'd0);
    chk("rst_oe", {31'b0, oe_a}, 32'd0);
    chk("rst_wr_pulse", {31'b0, wp_a}, 32'd0);
    chk("rst_wr_addr", {30'b0, wa_a}, 32'd0);
    chk("rst_busy", {31'b0, busy_a}, 32'd0);
    chk("rst_frame_err", {31'b0, fe_a}, 32'd0);
    chk("rst_a_ch", cd_a, 32'h0);
    chk("rst_b_ch", {8'b0, cd_b}, 32'h005C5C5C);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    frame(1'b1, 2'd2, 8'hA5, 1'b0, FL, 0);
    frame(1'b0, 2'd2, 8'h3C, 1'b0, FL, 2);
    frame(1'b1, 2'd1, 8'h77, 1'b0, 6, 0);
    clear_err();
    frame(1'b1, 2'd3, 8'h99, 1'b0, FL, 0);
    frame(1'b0, 2'd3, 8'h00, 1'b0, FL, 0);
`ifdef SPI_SLV_PARITY_EN
    frame(1'b1, 2'd1, 8'hA5, 1'b1, FL, 0);
    clear_err();
    frame(1'b1, 2'd1, 8'hA5, 1'b0, FL, 0);
`endif
    reset_mid_write();
    frame(1'b1, 2'd0, 8'h5A, 1'b0, FL, 0);

    repeat (24) begin
      rw = 1'($urandom_range(0, 1));
      ad = 2'($urandom_range(0, 3));
      dt = 8'($urandom);
      bad = (PW == 1) && ($urandom_range(0, 4) == 0);
      nb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, FL - 1)) : FL;
      frame(rw, ad, dt, bad, nb, int'($urandom_range(0, 2)));
      if (me_a || me_b) clear_err();
    end

    repeat (20) @(negedge clk);
    chk("a_wq_drained", wq_a.size(), 32'd0);
    chk("b_wq_drained", wq_b.size(), 32'd0);
    chk("a_rq_drained", rx_exp_a.size(), 32'd0);
    chk("b_rq_drained", rx_exp_b.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
